// File: rtl/axis_downsizer_pkg.sv
// -----------------------------------------------------------------------------
// axis_downsizer_pkg
//   Default geometry for the AXI-Stream width-reducing stage. Holds only the
//   parameter defaults so that every instance of the downsizer agrees with the
//   codebase-wide configuration unless it is overridden at instantiation.
// -----------------------------------------------------------------------------
package axis_downsizer_pkg;

    // Narrow (output) beat width in bytes.
    localparam int DS_DEFAULT_OUT_BYTES = 32'sd1;

    // Narrow beats emitted per wide input word.
    localparam int DS_DEFAULT_RATIO = 32'sd4;

    // Width of the tuser sideband carried unchanged through the stage.
    localparam int DS_DEFAULT_USER_BITS = 32'sd1;

endpackage : axis_downsizer_pkg

// File: rtl/axis_downsizer.sv
// -----------------------------------------------------------------------------
// axis_downsizer
//   Width-reducing AXI-Stream stage. A wide word of RATIO*OUT_BYTES bytes is
//   captured in a holding register and replayed as RATIO narrow beats, least
//   significant slice first. With a continuously ready sink it accepts one
//   word every RATIO cycles and emits beats without bubbles.
//
// Ports
//   clk            rising-edge clock
//   sreset         synchronous reset, active-high
//   axis_i_tready  input ready (combinational on axis_o_tready)
//   axis_i_tvalid  input valid
//   axis_i_tlast   input word ends a packet
//   axis_i_tdata   input word, OUT_BYTES*8*RATIO bits
//   axis_i_tuser   input sideband, AXIS_USER_BITS bits
//   axis_o_tready  output ready
//   axis_o_tvalid  output valid (registered)
//   axis_o_tlast   output beat ends a packet (from registers only)
//   axis_o_tdata   output beat, OUT_BYTES*8 bits
//   axis_o_tuser   output sideband, repeated on every beat of a word
// -----------------------------------------------------------------------------
module axis_downsizer
    import axis_downsizer_pkg::*;
#(
    parameter int OUT_BYTES      = DS_DEFAULT_OUT_BYTES,
    parameter int RATIO          = DS_DEFAULT_RATIO,
    parameter int AXIS_USER_BITS = DS_DEFAULT_USER_BITS
) (
    input  logic                          clk,
    input  logic                          sreset,

    output logic                          axis_i_tready,
    input  logic                          axis_i_tvalid,
    input  logic                          axis_i_tlast,
    input  logic [OUT_BYTES*8*RATIO-1:0]  axis_i_tdata,
    input  logic [AXIS_USER_BITS-1:0]     axis_i_tuser,

    input  logic                          axis_o_tready,
    output logic                          axis_o_tvalid,
    output logic                          axis_o_tlast,
    output logic [OUT_BYTES*8-1:0]        axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0]     axis_o_tuser
);

    localparam int BEAT_W = OUT_BYTES * 8;
    localparam int WORD_W = BEAT_W * RATIO;
    // A one-beat configuration still keeps a 1-bit index so the code stays uniform.
    localparam int IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // Holding register and beat sequencing state.
    logic [WORD_W-1:0]          held_data_r;
    logic                       held_last_r;
    logic [AXIS_USER_BITS-1:0]  held_user_r;
    logic [IDX_W-1:0]           idx_r;
    logic                       full_r;

    // Handshake decode.
    logic                       last_beat_s;
    logic                       ready_s;
    logic                       in_hs_s;
    logic                       out_hs_s;
    logic                       at_last_idx_s;

    // Handshake decode: a new word may enter when empty, or when the final
    // beat of the held word leaves on this same edge (no empty cycle between words).
    always_comb begin
        at_last_idx_s = 1'b0;
        last_beat_s   = 1'b0;
        ready_s       = 1'b0;
        in_hs_s       = 1'b0;
        out_hs_s      = 1'b0;

        at_last_idx_s = (idx_r == LAST_IDX);
        last_beat_s   = full_r && at_last_idx_s;
        ready_s       = !sreset && (!full_r || (axis_o_tready && last_beat_s));
        in_hs_s       = axis_i_tvalid && ready_s;
        // axis_o_tready is meaningless while nothing is presented.
        out_hs_s      = full_r && axis_o_tready;
    end

    // Holding register: captured only on an input handshake, so data, last and
    // user are stable for the whole time the word is being replayed.
    always_ff @(posedge clk) begin
        if (sreset) begin
            held_data_r <= '0;
            held_last_r <= 1'b0;
            held_user_r <= '0;
        end else if (in_hs_s) begin
            held_data_r <= axis_i_tdata;
            held_last_r <= axis_i_tlast;
            held_user_r <= axis_i_tuser;
        end else begin
            held_data_r <= held_data_r;
            held_last_r <= held_last_r;
            held_user_r <= held_user_r;
        end
    end

    // Beat index and full flag: a load restarts at beat 0; each accepted beat
    // advances the index until the last one, which empties the stage. A reset
    // mid-word simply drops the beats not yet sent.
    always_ff @(posedge clk) begin
        if (sreset) begin
            idx_r  <= IDX_ZERO;
            full_r <= 1'b0;
        end else if (in_hs_s) begin
            idx_r  <= IDX_ZERO;
            full_r <= 1'b1;
        end else if (out_hs_s) begin
            if (at_last_idx_s) begin
                idx_r  <= IDX_ZERO;
                full_r <= 1'b0;
            end else begin
                idx_r  <= idx_r + IDX_ONE;
                full_r <= 1'b1;
            end
        end else begin
            idx_r  <= idx_r;
            full_r <= full_r;
        end
    end

    assign axis_i_tready = ready_s;
    assign axis_o_tvalid = full_r;
    // Only the final slice of a word can close a packet.
    assign axis_o_tlast  = held_last_r && at_last_idx_s;
    assign axis_o_tuser  = held_user_r;
    // Slice k of the held word; idx_r never exceeds RATIO-1.
    assign axis_o_tdata  = held_data_r[int'(idx_r) * BEAT_W +: BEAT_W];

endmodule : axis_downsizer
